// File: rtl/dvg_vram_arbiter.sv
// Three-way vector RAM arbiter: CPU > DVG > DBG with DVG starvation override.
// Define DVG_VRAM_DBG_PORT_EN to arbitrate the debug snapshot port.
module dvg_vram_arbiter #(
    parameter int AW         = 13,
    parameter int DW         = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic          fastclk,
    input  logic          reset_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dvg_req,
    input  logic [AW-1:0] dvg_addr,
    output logic          dvg_ack,
    output logic          dvg_rvalid,
    output logic [DW-1:0] dvg_rdata,
    input  logic          dbg_req,
    input  logic [AW-1:0] dbg_addr,
    output logic          dbg_ack,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic [1:0]    owner
);

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DVG  = 2'd2,
        OWN_DBG  = 2'd3
    } owner_t;

    owner_t          w_grant;
    logic            w_dbg_req;
    logic [3:0]      r_starve;
    logic [AW-1:0]   r_addr;
    logic            r_cpu_rv;
    logic            r_dvg_rv;
    logic [DW-1:0]   r_cpu_rd;
    logic [DW-1:0]   r_dvg_rd;

`ifdef DVG_VRAM_DBG_PORT_EN
    assign w_dbg_req = dbg_req;
`else
    assign w_dbg_req = 1'b0;
    wire w_unused = ^{dbg_req, dbg_addr};
`endif

    // Reset forces the bus idle even while requests are held high.
    always_comb begin
        w_grant = OWN_NONE;
        if (!reset_n) begin
            w_grant = OWN_NONE;
        end else if (dvg_req && (r_starve == SMAX)) begin
            w_grant = OWN_DVG;
        end else if (cpu_req) begin
            w_grant = OWN_CPU;
        end else if (dvg_req) begin
            w_grant = OWN_DVG;
        end else if (w_dbg_req) begin
            w_grant = OWN_DBG;
        end
    end

    always_comb begin
        ram_addr  = reset_n ? r_addr : '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        case (w_grant)
            OWN_CPU: begin
                ram_addr  = cpu_addr;
                ram_we    = cpu_we;
                ram_wdata = cpu_we ? cpu_wdata : '0;
            end
            OWN_DVG: ram_addr = dvg_addr;
`ifdef DVG_VRAM_DBG_PORT_EN
            OWN_DBG: ram_addr = dbg_addr;
`endif
            default: ;
        endcase
    end

    assign owner   = w_grant;
    assign cpu_ack = (w_grant == OWN_CPU);
    assign dvg_ack = (w_grant == OWN_DVG);

    always_ff @(posedge fastclk) begin
        if (!reset_n) begin
            r_starve <= '0;
            r_addr   <= '0;
            r_cpu_rv <= 1'b0;
            r_dvg_rv <= 1'b0;
            r_cpu_rd <= '0;
            r_dvg_rd <= '0;
        end else begin
            if (w_grant != OWN_NONE) begin
                r_addr <= ram_addr;
            end
            r_cpu_rv <= (w_grant == OWN_CPU) && !cpu_we;
            r_dvg_rv <= (w_grant == OWN_DVG);
            if (r_cpu_rv) begin
                r_cpu_rd <= ram_rdata;
            end
            if (r_dvg_rv) begin
                r_dvg_rd <= ram_rdata;
            end
            if (!dvg_req || (w_grant == OWN_DVG)) begin
                r_starve <= '0;
            end else if (r_starve != SMAX) begin
                r_starve <= r_starve + 4'd1;
            end
        end
    end

    // RAM data lands in the rvalid cycle; the hold register keeps it afterwards.
    assign cpu_rvalid = reset_n & r_cpu_rv;
    assign dvg_rvalid = reset_n & r_dvg_rv;
    assign cpu_rdata  = !reset_n ? '0 : (r_cpu_rv ? ram_rdata : r_cpu_rd);
    assign dvg_rdata  = !reset_n ? '0 : (r_dvg_rv ? ram_rdata : r_dvg_rd);

`ifdef DVG_VRAM_DBG_PORT_EN
    logic          r_dbg_rv;
    logic [DW-1:0] r_dbg_rd;

    always_ff @(posedge fastclk) begin
        if (!reset_n) begin
            r_dbg_rv <= 1'b0;
            r_dbg_rd <= '0;
        end else begin
            r_dbg_rv <= (w_grant == OWN_DBG);
            if (r_dbg_rv) begin
                r_dbg_rd <= ram_rdata;
            end
        end
    end

    assign dbg_ack    = (w_grant == OWN_DBG);
    assign dbg_rvalid = reset_n & r_dbg_rv;
    assign dbg_rdata  = !reset_n ? '0 : (r_dbg_rv ? ram_rdata : r_dbg_rd);
`else
    assign dbg_ack    = 1'b0;
    assign dbg_rvalid = 1'b0;
    assign dbg_rdata  = '0;
`endif

endmodule
